// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: resolves memory waits, halt drain, branch
// flush, load-use interlock and fetch misses into per-stage enables and flushes.
module pipeline_ctrl #(
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            dren_mem,
  input  logic            dwen_mem,
  input  logic            memread_ex,
  input  logic [4:0]      rt_ex,
  input  logic [4:0]      rs_id,
  input  logic [4:0]      rt_id,
  input  logic            uses_rt_id,
  input  logic            branch_ex,
  input  logic            halt_mem,
  output logic            pc_en,
  output logic            en_ifid,
  output logic            en_idex,
  output logic            en_exmem,
  output logic            en_memwb,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            flush_exmem,
  output logic            halt,
  output logic [CNTW-1:0] stall_cnt,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state, next_state;

  logic memwait;
  logic loaduse;
  logic stall_inc;

  logic pc_en_c;
  logic en_ifid_c, en_idex_c, en_exmem_c, en_memwb_c;
  logic flush_ifid_c, flush_idex_c, flush_exmem_c;
  logic halt_c;

  assign memwait = (dren_mem | dwen_mem) & ~dhit;
  assign loaduse = memread_ex & (rt_ex != 5'd0) &
                   ((rt_ex == rs_id) | (uses_rt_id & (rt_ex == rt_id)));

  assign dbg_state = state;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: HALTED is only left through reset
  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (!memwait && halt_mem) begin
          next_state = DRAIN;
        end
      end
      DRAIN:   next_state = HALTED;
      HALTED:  next_state = HALTED;
      default: next_state = RUN;
    endcase
  end

  // Output logic; each RUN branch sets only the enables/flushes it needs
  always_comb begin
    pc_en_c       = 1'b0;
    en_ifid_c     = 1'b0;
    en_idex_c     = 1'b0;
    en_exmem_c    = 1'b0;
    en_memwb_c    = 1'b0;
    flush_ifid_c  = 1'b0;
    flush_idex_c  = 1'b0;
    flush_exmem_c = 1'b0;
    halt_c        = 1'b0;
    case (state)
      RUN: begin
        if (memwait) begin
          // full freeze: everything already defaulted to 0
        end else if (halt_mem) begin
          en_memwb_c    = 1'b1;
          flush_ifid_c  = 1'b1;
          flush_idex_c  = 1'b1;
          flush_exmem_c = 1'b1;
        end else if (branch_ex) begin
          pc_en_c      = 1'b1;
          flush_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
          en_exmem_c   = 1'b1;
          en_memwb_c   = 1'b1;
        end else if (loaduse) begin
          flush_idex_c = 1'b1;
          en_exmem_c   = 1'b1;
          en_memwb_c   = 1'b1;
        end else if (!ihit) begin
          flush_ifid_c = 1'b1;
          en_idex_c    = 1'b1;
          en_exmem_c   = 1'b1;
          en_memwb_c   = 1'b1;
        end else begin
          pc_en_c    = 1'b1;
          en_ifid_c  = 1'b1;
          en_idex_c  = 1'b1;
          en_exmem_c = 1'b1;
          en_memwb_c = 1'b1;
        end
      end
      DRAIN: begin
        flush_ifid_c  = 1'b1;
        flush_idex_c  = 1'b1;
        flush_exmem_c = 1'b1;
        halt_c        = 1'b1;
      end
      HALTED: begin
        halt_c = 1'b1;
      end
      default: begin
        halt_c = 1'b0;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held
  assign pc_en       = pc_en_c       & nRST;
  assign en_ifid     = en_ifid_c     & nRST;
  assign en_idex     = en_idex_c     & nRST;
  assign en_exmem    = en_exmem_c    & nRST;
  assign en_memwb    = en_memwb_c    & nRST;
  assign flush_ifid  = flush_ifid_c  & nRST;
  assign flush_idex  = flush_idex_c  & nRST;
  assign flush_exmem = flush_exmem_c & nRST;
  assign halt        = halt_c        & nRST;

  // The halt_mem cycle holds the PC but is a drain, not a stall
  assign stall_inc = (state == RUN) & ~pc_en_c & ~(halt_mem & ~memwait);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: table of single-cycle RUN responses plus
// hand sequences for memwait priority, halt drain, reset and saturation.
module tb_pipeline_ctrl;

  logic       CLK;
  logic       nRST;
  logic       ihit, dhit, dren_mem, dwen_mem, memread_ex;
  logic [4:0] rt_ex, rs_id, rt_id;
  logic       uses_rt_id, branch_ex, halt_mem;

  logic        pc_en, en_ifid, en_idex, en_exmem, en_memwb;
  logic        flush_ifid, flush_idex, flush_exmem, halt;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  logic        pc_en4, en_ifid4, en_idex4, en_exmem4, en_memwb4;
  logic        flush_ifid4, flush_idex4, flush_exmem4, halt4;
  logic [3:0]  stall_cnt4;
  logic [1:0]  dbg_state4;

  logic [8:0] outs;
  assign outs = {pc_en, en_ifid, en_idex, en_exmem, en_memwb,
                 flush_ifid, flush_idex, flush_exmem, halt};

  pipeline_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dren_mem(dren_mem),
    .dwen_mem(dwen_mem), .memread_ex(memread_ex), .rt_ex(rt_ex), .rs_id(rs_id),
    .rt_id(rt_id), .uses_rt_id(uses_rt_id), .branch_ex(branch_ex),
    .halt_mem(halt_mem), .pc_en(pc_en), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exmem(en_exmem), .en_memwb(en_memwb), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .flush_exmem(flush_exmem), .halt(halt),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  pipeline_ctrl #(.CNTW(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dren_mem(dren_mem),
    .dwen_mem(dwen_mem), .memread_ex(memread_ex), .rt_ex(rt_ex), .rs_id(rs_id),
    .rt_id(rt_id), .uses_rt_id(uses_rt_id), .branch_ex(branch_ex),
    .halt_mem(halt_mem), .pc_en(pc_en4), .en_ifid(en_ifid4), .en_idex(en_idex4),
    .en_exmem(en_exmem4), .en_memwb(en_memwb4), .flush_ifid(flush_ifid4),
    .flush_idex(flush_idex4), .flush_exmem(flush_exmem4), .halt(halt4),
    .stall_cnt(stall_cnt4), .dbg_state(dbg_state4)
  );

  // Clock/reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // {pc_en, en_ifid, en_idex, en_exmem, en_memwb, fl_ifid, fl_idex, fl_exmem, halt}
  localparam logic [8:0] NORM  = 9'b1_1111_000_0;
  localparam logic [8:0] LU    = 9'b0_0011_010_0;
  localparam logic [8:0] NOHIT = 9'b0_0111_100_0;
  localparam logic [8:0] BR    = 9'b1_0011_110_0;
  localparam logic [8:0] FRZ   = 9'b0_0000_000_0;
  localparam logic [8:0] HMEM  = 9'b0_0001_111_0;
  localparam logic [8:0] DRN   = 9'b0_0000_111_1;
  localparam logic [8:0] HLT   = 9'b0_0000_000_1;

  typedef struct {
    logic       ihit, dhit, dren, dwen, mrd;
    logic [4:0] rt_ex, rs_id, rt_id;
    logic       uses_rt, br, hm;
    logic [8:0] exp;
    logic       inc;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  vec_t vecs[12];

  function automatic vec_t mk(input logic ih, dh, dr, dw, mr,
                              input logic [4:0] rte, rsi, rti,
                              input logic ur, b, h,
                              input logic [8:0] e, input logic inc);
    vec_t v;
    v.ihit = ih; v.dhit = dh; v.dren = dr; v.dwen = dw; v.mrd = mr;
    v.rt_ex = rte; v.rs_id = rsi; v.rt_id = rti;
    v.uses_rt = ur; v.br = b; v.hm = h; v.exp = e; v.inc = inc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver
  task automatic apply(input vec_t v);
    ihit = v.ihit; dhit = v.dhit; dren_mem = v.dren; dwen_mem = v.dwen;
    memread_ex = v.mrd; rt_ex = v.rt_ex; rs_id = v.rs_id; rt_id = v.rt_id;
    uses_rt_id = v.uses_rt; branch_ex = v.br; halt_mem = v.hm;
  endtask

  // One cycle: drive after negedge, check comb outputs, then count after posedge
  task automatic cycle_check(input string name, input vec_t v);
    @(negedge CLK);
    apply(v);
    #1;
    check({name, "_outs"}, {23'd0, outs}, {23'd0, v.exp});
    @(posedge CLK);
    #1;
    if (v.inc) exp_cnt++;
    check({name, "_cnt"}, {16'd0, stall_cnt}, exp_cnt);
  endtask

  initial begin
    vec_t nv, sv, mw, hv, junk;

    //            ih dh dr dw mr rt_ex  rs_id  rt_id  ur br hm exp    inc
    vecs[0]  = mk(1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, NORM,  0);
    vecs[1]  = mk(1, 0, 0, 0, 1, 5'd8,  5'd8,  5'd1,  0, 0, 0, LU,    1);
    vecs[2]  = mk(1, 0, 0, 0, 1, 5'd0,  5'd0,  5'd0,  1, 0, 0, NORM,  0);
    vecs[3]  = mk(1, 0, 0, 0, 1, 5'd5,  5'd3,  5'd5,  1, 0, 0, LU,    1);
    vecs[4]  = mk(1, 0, 0, 0, 1, 5'd5,  5'd3,  5'd5,  0, 0, 0, NORM,  0);
    vecs[5]  = mk(0, 0, 0, 0, 1, 5'd31, 5'd31, 5'd2,  0, 0, 0, LU,    1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 5'd8,  5'd8,  5'd8,  1, 0, 0, NOHIT, 1);
    vecs[7]  = mk(0, 0, 0, 0, 1, 5'd8,  5'd8,  5'd8,  1, 1, 0, BR,    0);
    vecs[8]  = mk(1, 0, 1, 0, 1, 5'd8,  5'd8,  5'd0,  0, 1, 0, FRZ,   1);
    vecs[9]  = mk(1, 1, 0, 1, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, NORM,  0);
    vecs[10] = mk(1, 0, 0, 1, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, FRZ,   1);
    vecs[11] = mk(1, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 1, FRZ,   1);

    nv   = vecs[0];
    sv   = mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NOHIT, 1);
    mw   = mk(1, 0, 1, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, FRZ, 1);
    hv   = mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, HMEM, 0);
    junk = mk(0, 1, 1, 1, 1, 5'd8, 5'd8, 5'd8, 1, 1, 1, HLT, 0);

    // Reset: outputs quiet even though inputs ask for normal flow
    nRST = 1'b0;
    apply(nv);
    #2;
    check("reset_outs", {23'd0, outs}, 32'd0);
    check("reset_cnt", {16'd0, stall_cnt}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 10; i++) cycle_check($sformatf("normal%0d", i), nv);

    // memwait beats branch and load-use; count stalls; dhit releases to branch
    for (int i = 0; i < 3; i++) cycle_check($sformatf("memwait%0d", i), mw);
    check("memwait_cnt3", {16'd0, stall_cnt}, 32'd3);
    mw.dhit = 1'b1; mw.exp = BR; mw.inc = 1'b0;
    cycle_check("memwait_release", mw);

    for (int i = 0; i < 12; i++) cycle_check($sformatf("vec%0d", i), vecs[i]);

    // Halt: drain cycle, then HALTED ignoring inputs with count held
    cycle_check("halt_mem", hv);
    junk.exp = DRN;
    cycle_check("drain", junk);
    junk.exp = HLT;
    for (int i = 0; i < 4; i++) cycle_check($sformatf("halted%0d", i), junk);

    // Reset while HALTED
    @(negedge CLK);
    apply(nv);
    nRST = 1'b0;
    #1;
    check("rst_halted_outs", {23'd0, outs}, 32'd0);
    check("rst_halted_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_halted_cnt4", {28'd0, stall_cnt4}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 2; i++) cycle_check($sformatf("post_rst%0d", i), nv);

    // Saturation on the 4-bit instance; the 16-bit one keeps counting
    for (int i = 1; i <= 20; i++) begin
      cycle_check($sformatf("sat%0d", i), sv);
      check($sformatf("sat4_%0d", i), {28'd0, stall_cnt4}, (i > 15) ? 32'd15 : i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
